imem_loader: RTL

Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words, and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset while loading.
- Releases the CPU once a 32'd0 terminator word (the end-of-program marker) has been written, or once memory is full.
- Sits between the host/bench byte source and the instruction-memory write port, alongside the single-cycle CPU.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_packer.sv | 50 +++++
 rtl/imem_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared FSM state type and program-image constants for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned IMEM_DEPTH = 2 ** DEF_ADDR_W;
    localparam logic [31:0] END_WORD   = 32'd0;

    function automatic logic is_end_word(input logic [31:0] w);
        return (w == END_WORD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream handshake plus instruction-memory write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              im_we_o;
    logic [31:0]       im_addr_o;
    logic [31:0]       im_data_o;

    // master = byte source / memory side, slave = the loader
    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, im_we_o, im_addr_o, im_data_o
    );

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, im_we_o, im_addr_o, im_data_o
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
// Module   : imem_loader_byte_packer
// Brief    : Shifts MSB-first bytes into a word; flags the 4th accepted byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader_byte_packer #(
    parameter int BYTE_W = 8
) (
    input  wire logic                clk_i,
    input  wire logic                rst_n,
    input  wire logic                clr_i,
    input  wire logic                xfer_i,
    input  wire logic [BYTE_W-1:0]   byte_i,
    output logic      [4*BYTE_W-1:0] word_o,
    output logic                     word_valid_o
);
    logic [4*BYTE_W-1:0] shreg_q, shreg_d;
    logic [1:0]          cnt_q, cnt_d;

    // word_o is the word as it will look once the current byte is shifted in
    assign word_o       = {shreg_q[3*BYTE_W-1:0], byte_i};
    assign word_valid_o = xfer_i && (cnt_q == 2'd3);

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (xfer_i) begin
            shreg_d = word_o;
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Loads a byte-streamed program into instruction memory, holding
//            the CPU in reset until a zero terminator word or a full memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int BYTE_W = 8
) (
    input  wire logic        clk_i,
    input  wire logic        rst_n,
    input  wire logic        start_i,
    imem_loader_if.slave     bus,
    output logic             cpu_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [ADDR_W:0]  word_cnt_o,
    output logic             overflow_o
);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              overflow_q, overflow_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic [31:0]       im_addr_q, im_addr_d;
    logic [31:0]       im_data_q, im_data_d;

    logic              w_ready;
    logic              w_clr;
    logic              w_xfer;
    logic [31:0]       w_word;
    logic              w_word_valid;

    assign w_xfer = bus.byte_valid_i && w_ready;

    imem_loader_byte_packer #(
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .clr_i        (w_clr),
        .xfer_i       (w_xfer),
        .byte_i       (bus.byte_i),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        word_cnt_d  = word_cnt_q;
        overflow_d  = overflow_q;
        im_addr_d   = im_addr_q;
        im_data_d   = im_data_q;
        w_clr       = 1'b0;
        w_ready     = 1'b0;
        cpu_rst_n_d = 1'b0;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (start_i) begin
                    state_d    = S_RECV;
                    word_idx_d = '0;
                    word_cnt_d = '0;
                    overflow_d = 1'b0;
                    w_clr      = 1'b1;
                end
            end
            S_RECV: begin
                w_ready = 1'b1;
                // Latch the write address/data so they hold after the strobe
                if (w_word_valid) begin
                    state_d   = S_WRITE;
                    im_addr_d = {{(32-ADDR_W-2){1'b0}}, word_idx_q, 2'b00};
                    im_data_d = w_word;
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + CNT_ONE;
                if (is_end_word(im_data_q)) begin
                    state_d = S_RUN;
                end else if (word_idx_q == LAST_IDX) begin
                    state_d    = S_RUN;
                    overflow_d = 1'b1;
                end else begin
                    word_idx_d = word_idx_q + IDX_ONE;
                    state_d    = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_rst_n_d = (state_q == S_RUN) && (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_idx_q  <= '0;
            word_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            im_addr_q   <= '0;
            im_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            word_cnt_q  <= word_cnt_d;
            overflow_q  <= overflow_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            im_addr_q   <= im_addr_d;
            im_data_q   <= im_data_d;
        end
    end

    assign bus.byte_ready_o = w_ready;
    assign bus.im_we_o      = (state_q == S_WRITE);
    assign bus.im_addr_o    = im_addr_q;
    assign bus.im_data_o    = im_data_q;
    assign cpu_rst_n_o      = cpu_rst_n_q;
    assign busy_o           = (state_q == S_RECV) || (state_q == S_WRITE);
    assign done_o           = (state_q == S_RUN);
    assign word_cnt_o       = word_cnt_q;
    assign overflow_o       = overflow_q;

endmodule

`default_nettype wire
